oob_downstream_cntl: RTL and testbench
======================================

# oob_downstream_cntl

Serializes manager work-unit configuration requests into tagged packets on the stack-bus OOB downstream interface. It allocates a tag per packet and tracks outstanding tags until the upstream return path releases them. It throttles WU fetch when no tag is free. Sits between the WU decoder and the `mgr__std__oob_*` port of the manager.

## Interface
Parameters:
- `OPT_PER_INST`, 3: maximum option beats per request.
- `OPT_TYPE_W`, 8: option type width.
- `OPT_VALUE_W`, 8: option value width.
- `TAG_W`, 3: tag width; `2**TAG_W` tags tracked.
- `MGR_ID_W`, 8: manager id width.
- `OOB_DATA_W`, 32: OOB data width.

Ports:
- `clk`, in, 1: the single clock.
- `reset_poweron`, in, 1: synchronous, active-low reset.
- `sys__mgr__mgrId`, in, MGR_ID_W: manager id, placed in the header.
- `wud__odc__valid`, in, 1: request valid.
- `odc__wud__ready`, out, 1: request accepted when both valid and ready are high.
- `wud__odc__num_opts`, in, 2: option count, 0..3.
- `wud__odc__option_type`, in, OPT_PER_INST*OPT_TYPE_W: option types, option i in slice i.
- `wud__odc__option_value`, in, OPT_PER_INST*OPT_VALUE_W: option values, option i in slice i.
- `odc__wud__tag`, out, TAG_W: tag allocated to the accepted request; valid in the cycle after acceptance.
- `mgr__std__oob_valid`, out, 1: OOB beat valid.
- `std__mgr__oob_ready`, in, 1: OOB beat accepted when both valid and ready are high.
- `mgr__std__oob_cntl`, out, 2: beat delineator (SOM/MOM/EOM/SOM_EOM).
- `mgr__std__oob_type`, out, 2: beat type, HDR or OPT.
- `mgr__std__oob_data`, out, OOB_DATA_W: beat payload.
- `rdp__odc__release_valid`, in, 1: tag release strobe.
- `rdp__odc__release_tag`, in, TAG_W: tag to free.
- `odc__wuf__stall`, out, 1: high when no tag is free.
- `odc__mcntl__outstanding`, out, TAG_W+1: count of tags in use.
- `odc__sys__tag_err`, out, 1: sticky flag; release of a tag that is not in use.

## Operation
- State machine: IDLE, HDR, OPT.
- IDLE:
  - `odc__wud__ready = (free bitmap != 0)`.
  - On accept: latch options and `min(num_opts, OPT_PER_INST)`, allocate the lowest-index free tag, set its busy bit, go to HDR.
- HDR:
  - Drive valid=1, type=HDR.
  - data = {mgrId[31:24], 6'b0, num_opts[17:16], 8'b0, zero-extended tag[7:0]}.
  - cntl = SOM_EOM if num_opts==0, else SOM.
  - On ready: go to IDLE if num_opts==0; otherwise go to OPT with idx=0.
- OPT:
  - Drive type=OPT, data = {16'b0, option_type[idx], option_value[idx]}.
  - cntl = EOM when idx==num_opts-1, else MOM.
  - On ready: if last beat go to IDLE, else idx++.
- Release:
  - If the tag is busy, clear its bit.
  - If the tag is not busy, ignore it and set `tag_err` (sticky until reset).
- Same cycle allocate and release:
  - Both apply.
  - A freed tag becomes allocatable from the next cycle.
  - A release of the tag being allocated in that same cycle is treated as a release of a non-busy tag and sets `tag_err`.
- `outstanding` = popcount of the busy bitmap. `stall` = (outstanding == 2**TAG_W).

## Timing
- All outputs are registered except `odc__wud__ready` and `odc__wuf__stall`, which are combinational from state and the bitmap.
- Reset values: valid=0, cntl=0, type=0, data=0, tag=0, outstanding=0, tag_err=0, state=IDLE, bitmap clear.
- Accept at cycle t puts the first OOB beat valid at t+1.
- One packet takes num_opts+1 beats with ready held high. The next accept is possible in the cycle after EOM completes, giving a 1-cycle bubble.
- valid, cntl, type and data are held stable while ready is low. Ready may toggle arbitrarily.
- Reset mid-packet: valid drops on the next edge and all tags are freed. No packet is resumed.

## Structure
- Shared package `oob_downstream_cntl.vh` holds:
  - cntl encodings: SOM=2'b01, MOM=2'b00, EOM=2'b10, SOM_EOM=2'b11.
  - type encodings: HDR=2'b01, OPT=2'b10.
  - state encodings.
  - header field ranges.
- One natural sub-module, `tag_alloc`: the busy bitmap, lowest-free priority encoder, release logic, popcount and error flag.

## Test plan
- mgrId=0x05, request num_opts=2 with opts {(0x11,0xA1),(0x22,0xB2)}, ready=1. Expect tag 0, then three beats:
  - beat 1: SOM/HDR, data 0x05020000.
  - beat 2: MOM/OPT, data 0x000011A1.
  - beat 3: EOM/OPT, data 0x000022B2.
  - Then outstanding=1.
- num_opts=0. Expect a single beat with SOM_EOM/HDR, then a return to IDLE.
- Ready held low for 5 cycles during the OPT beat. Expect valid, cntl, type and data unchanged, then the packet completes once ready rises.
- Issue 8 requests with no releases:
  - tags 0..7 are allocated in order;
  - stall=1 and `odc__wud__ready`=0 after the 8th;
  - releasing tag 3 makes the next request get tag 3.
- Release tag 5 while it is not busy. Expect tag_err=1 that persists and bitmap unchanged. Release tag 2 in the same cycle as the 9th allocation. Expect tag 2 allocatable on the next request.
- Assert reset in the middle of the HDR beat. Expect valid=0, outstanding=0 and state IDLE on the next edge.

Source files
------------

// File: rtl/oob_downstream_cntl_pkg.sv
// rtl/oob_downstream_cntl_pkg.sv - shared encodings and helpers for the OOB downstream controller
// Contents: beat delineator (cntl) codes, beat type codes, FSM states,
// header field positions, and a cntl helper used by the top.
package oob_downstream_cntl_pkg;

    // Beat delineator encodings
    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    // Beat type encodings; NONE is the idle/reset value
    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_HDR  = 2'b01;
    localparam logic [1:0] TYPE_OPT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_OPT  = 2'd2
    } odc_state_t;

    // Header field positions inside the OOB data word
    localparam int HDR_MGR_LSB   = 24;
    localparam int HDR_NOPTS_LSB = 16;
    localparam int HDR_NOPTS_W   = 2;
    localparam int HDR_TAG_LSB   = 0;

    // Delineator for a beat given whether it opens and/or closes a packet
    function automatic logic [1:0] beat_cntl(input logic first, input logic last);
        case ({first, last})
            2'b11:   return CNTL_SOM_EOM;
            2'b10:   return CNTL_SOM;
            2'b01:   return CNTL_EOM;
            default: return CNTL_MOM;
        endcase
    endfunction

endpackage

// File: rtl/oob_downstream_cntl_if.sv
// rtl/oob_downstream_cntl_if.sv - request and OOB beat channels of the downstream controller
// master: the controller (accepts WU requests, drives OOB beats).
// slave:  the environment (WU decoder plus stack-bus OOB sink).
interface oob_downstream_cntl_if #(
    parameter int OPT_PER_INST = 3,
    parameter int OPT_TYPE_W   = 8,
    parameter int OPT_VALUE_W  = 8,
    parameter int TAG_W        = 3,
    parameter int OOB_DATA_W   = 32
);
    // WU decoder request channel
    logic                                wud__odc__valid;
    logic                                odc__wud__ready;
    logic [1:0]                          wud__odc__num_opts;
    logic [OPT_PER_INST*OPT_TYPE_W-1:0]  wud__odc__option_type;
    logic [OPT_PER_INST*OPT_VALUE_W-1:0] wud__odc__option_value;
    logic [TAG_W-1:0]                    odc__wud__tag;

    // Stack-bus OOB downstream channel
    logic                                mgr__std__oob_valid;
    logic                                std__mgr__oob_ready;
    logic [1:0]                          mgr__std__oob_cntl;
    logic [1:0]                          mgr__std__oob_type;
    logic [OOB_DATA_W-1:0]               mgr__std__oob_data;

    modport master (
        input  wud__odc__valid, wud__odc__num_opts, wud__odc__option_type,
               wud__odc__option_value, std__mgr__oob_ready,
        output odc__wud__ready, odc__wud__tag, mgr__std__oob_valid,
               mgr__std__oob_cntl, mgr__std__oob_type, mgr__std__oob_data
    );

    modport slave (
        output wud__odc__valid, wud__odc__num_opts, wud__odc__option_type,
               wud__odc__option_value, std__mgr__oob_ready,
        input  odc__wud__ready, odc__wud__tag, mgr__std__oob_valid,
               mgr__std__oob_cntl, mgr__std__oob_type, mgr__std__oob_data
    );
endinterface

// File: rtl/oob_downstream_cntl_tag_alloc.sv
// rtl/oob_downstream_cntl_tag_alloc.sv - tag busy bitmap, lowest-free allocator, release and error tracking
// Ports: alloc_en/alloc_tag (allocate lowest free tag), release_valid/release_tag,
// any_free/all_busy (combinational from bitmap), outstanding (registered popcount),
// tag_err (sticky release-of-free-tag flag).
module oob_downstream_cntl_tag_alloc #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             reset_poweron,
    input  logic             alloc_en,
    input  logic             release_valid,
    input  logic [TAG_W-1:0] release_tag,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             any_free,
    output logic             all_busy,
    output logic [TAG_W:0]   outstanding,
    output logic             tag_err
);
    localparam int TAG_N = 1 << TAG_W;

    logic [TAG_N-1:0] busy_q;
    logic [TAG_N-1:0] busy_d;
    logic [TAG_N-1:0] set_mask;
    logic [TAG_N-1:0] clr_mask;
    logic [TAG_W:0]   cnt_d;
    logic             rel_hit;

    // Lowest-index free tag: scan downward so the last hit wins
    always_comb begin
        alloc_tag = '0;
        for (int i = TAG_N - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_tag = TAG_W'(i);
        end
    end

    assign any_free = ~&busy_q;
    assign all_busy = &busy_q;

    // A release is judged against the current bitmap only, so releasing the
    // tag being allocated this cycle counts as releasing a free tag.
    assign rel_hit = busy_q[release_tag];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (alloc_en) set_mask[alloc_tag] = 1'b1;
        if (release_valid && rel_hit) clr_mask[release_tag] = 1'b1;
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < TAG_N; i++) begin
            cnt_d = cnt_d + {{TAG_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            busy_q      <= '0;
            outstanding <= '0;
            tag_err     <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            outstanding <= cnt_d;
            if (release_valid && !rel_hit) tag_err <= 1'b1;
        end
    end
endmodule

// File: rtl/oob_downstream_cntl.sv
// rtl/oob_downstream_cntl.sv - serializes WU configuration requests into tagged OOB downstream packets
// Ports: clk, reset_poweron (sync, active-low), sys__mgr__mgrId,
// bus (request + OOB beat channels), rdp__odc__release_valid/_tag,
// odc__wuf__stall, odc__mcntl__outstanding, odc__sys__tag_err.
module oob_downstream_cntl
    import oob_downstream_cntl_pkg::*;
#(
    parameter int OPT_PER_INST = 3,
    parameter int OPT_TYPE_W   = 8,
    parameter int OPT_VALUE_W  = 8,
    parameter int TAG_W        = 3,
    parameter int MGR_ID_W     = 8,
    parameter int OOB_DATA_W   = 32
) (
    input  logic                clk,
    input  logic                reset_poweron,
    input  logic [MGR_ID_W-1:0] sys__mgr__mgrId,
    oob_downstream_cntl_if.master bus,
    input  logic                rdp__odc__release_valid,
    input  logic [TAG_W-1:0]    rdp__odc__release_tag,
    output logic                odc__wuf__stall,
    output logic [TAG_W:0]      odc__mcntl__outstanding,
    output logic                odc__sys__tag_err
);
    localparam int TYPES_W  = OPT_PER_INST * OPT_TYPE_W;
    localparam int VALUES_W = OPT_PER_INST * OPT_VALUE_W;

    odc_state_t state_q, state_n;
    logic [1:0] idx_q, idx_n;

    // Latched request
    logic [1:0]          nopts_q;
    logic [TYPES_W-1:0]  otype_q;
    logic [VALUES_W-1:0] ovalue_q;
    logic [TAG_W-1:0]    tag_q;

    // Request contents as they will be after this edge
    logic [1:0]          nopts_req, nopts_d;
    logic [TYPES_W-1:0]  otype_d;
    logic [VALUES_W-1:0] ovalue_d;
    logic [TAG_W-1:0]    tag_d;

    // Next registered beat
    logic                  valid_d;
    logic [1:0]            cntl_d;
    logic [1:0]            type_d;
    logic [OOB_DATA_W-1:0] data_d;

    logic             accept;
    logic             beat_done;
    logic             last_opt;
    logic             any_free;
    logic             all_busy;
    logic [TAG_W-1:0] alloc_tag;

    oob_downstream_cntl_tag_alloc #(
        .TAG_W(TAG_W)
    ) u_tag_alloc (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .alloc_en      (accept),
        .release_valid (rdp__odc__release_valid),
        .release_tag   (rdp__odc__release_tag),
        .alloc_tag     (alloc_tag),
        .any_free      (any_free),
        .all_busy      (all_busy),
        .outstanding   (odc__mcntl__outstanding),
        .tag_err       (odc__sys__tag_err)
    );

    assign bus.odc__wud__ready = (state_q == ST_IDLE) && any_free;
    assign odc__wuf__stall     = all_busy;
    assign bus.odc__wud__tag   = tag_q;

    assign accept    = bus.wud__odc__valid && bus.odc__wud__ready;
    assign beat_done = bus.mgr__std__oob_valid && bus.std__mgr__oob_ready;
    assign last_opt  = (idx_q == 2'(nopts_q - 2'd1));

    assign nopts_req = (32'(bus.wud__odc__num_opts) > OPT_PER_INST) ?
                       2'(OPT_PER_INST) : bus.wud__odc__num_opts;
    assign nopts_d   = accept ? nopts_req : nopts_q;
    assign otype_d   = accept ? bus.wud__odc__option_type  : otype_q;
    assign ovalue_d  = accept ? bus.wud__odc__option_value : ovalue_q;
    assign tag_d     = accept ? alloc_tag : tag_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_HDR;
                    idx_n   = '0;
                end
            end
            ST_HDR: begin
                if (beat_done) begin
                    if (nopts_q == 2'd0) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_OPT;
                        idx_n   = '0;
                    end
                end
            end
            ST_OPT: begin
                if (beat_done) begin
                    if (last_opt) state_n = ST_IDLE;
                    else          idx_n   = idx_q + 2'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output logic: build the beat that will be presented after this edge.
    // Because it depends only on next state/index and the latched request,
    // a stalled beat (ready low) recomputes to the same value.
    always_comb begin
        valid_d = 1'b0;
        cntl_d  = CNTL_MOM;
        type_d  = TYPE_NONE;
        data_d  = '0;
        case (state_n)
            ST_HDR: begin
                valid_d = 1'b1;
                type_d  = TYPE_HDR;
                cntl_d  = beat_cntl(1'b1, nopts_d == 2'd0);
                data_d[HDR_MGR_LSB +: MGR_ID_W]      = sys__mgr__mgrId;
                data_d[HDR_NOPTS_LSB +: HDR_NOPTS_W] = nopts_d;
                data_d[HDR_TAG_LSB +: TAG_W]         = tag_d;
            end
            ST_OPT: begin
                valid_d = 1'b1;
                type_d  = TYPE_OPT;
                cntl_d  = beat_cntl(1'b0, idx_n == 2'(nopts_d - 2'd1));
                data_d[0 +: OPT_VALUE_W] =
                    ovalue_d[int'(idx_n) * OPT_VALUE_W +: OPT_VALUE_W];
                data_d[OPT_VALUE_W +: OPT_TYPE_W] =
                    otype_d[int'(idx_n) * OPT_TYPE_W +: OPT_TYPE_W];
            end
            default: ;
        endcase
    end

    // Request latch
    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            nopts_q  <= '0;
            otype_q  <= '0;
            ovalue_q <= '0;
            tag_q    <= '0;
        end else begin
            nopts_q  <= nopts_d;
            otype_q  <= otype_d;
            ovalue_q <= ovalue_d;
            tag_q    <= tag_d;
        end
    end

    // Registered OOB beat
    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            bus.mgr__std__oob_valid <= 1'b0;
            bus.mgr__std__oob_cntl  <= '0;
            bus.mgr__std__oob_type  <= '0;
            bus.mgr__std__oob_data  <= '0;
        end else begin
            bus.mgr__std__oob_valid <= valid_d;
            bus.mgr__std__oob_cntl  <= cntl_d;
            bus.mgr__std__oob_type  <= type_d;
            bus.mgr__std__oob_data  <= data_d;
        end
    end
endmodule

// File: tb/tb_oob_downstream_cntl.sv
// tb/tb_oob_downstream_cntl.sv - self-checking bench for oob_downstream_cntl
module tb_oob_downstream_cntl;
    logic       clk = 1'b0;
    logic       reset_poweron;
    logic [7:0] mgr_id;
    logic       rel_valid;
    logic [2:0] rel_tag;
    logic       stall;
    logic [3:0] outstanding;
    logic       tag_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which tags are held, and the sticky error
    bit busy_m[8];
    bit err_m;

    oob_downstream_cntl_if bus ();

    oob_downstream_cntl dut (
        .clk                     (clk),
        .reset_poweron           (reset_poweron),
        .sys__mgr__mgrId         (mgr_id),
        .bus                     (bus),
        .rdp__odc__release_valid (rel_valid),
        .rdp__odc__release_tag   (rel_tag),
        .odc__wuf__stall         (stall),
        .odc__mcntl__outstanding (outstanding),
        .odc__sys__tag_err       (tag_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < 8; i++) if (!busy_m[i]) return i;
        return -1;
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += busy_m[i] ? 1 : 0;
        return c;
    endfunction

    task automatic do_reset();
        bus.wud__odc__valid = 1'b0;
        rel_valid           = 1'b0;
        reset_poweron       = 1'b0;
        step();
        step();
        reset_poweron = 1'b1;
        for (int i = 0; i < 8; i++) busy_m[i] = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic release_tag(input logic [2:0] t);
        rel_valid = 1'b1;
        rel_tag   = t;
        step();
        rel_valid = 1'b0;
    endtask

    task automatic send_req(input logic [1:0] n, input logic [23:0] ty, input logic [23:0] va);
        bit rdy;
        bit ok = 1'b0;
        bus.wud__odc__valid        = 1'b1;
        bus.wud__odc__num_opts     = n;
        bus.wud__odc__option_type  = ty;
        bus.wud__odc__option_value = va;
        for (int i = 0; i < 30; i++) begin
            rdy = bus.odc__wud__ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.wud__odc__valid = 1'b0;
        chk("req_accept", ok, 1);
    endtask

    task automatic take_beat(input bit rnd, output logic [1:0] c, output logic [1:0] t,
                             output logic [31:0] d);
        bit ok = 1'b0;
        c = 'x; t = 'x; d = 'x;
        for (int i = 0; i < 64; i++) begin
            if (rnd) bus.std__mgr__oob_ready = ($urandom_range(0, 2) != 0);
            if (bus.mgr__std__oob_valid && bus.std__mgr__oob_ready) begin
                c = bus.mgr__std__oob_cntl;
                t = bus.mgr__std__oob_type;
                d = bus.mgr__std__oob_data;
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("beat_seen", ok, 1);
    endtask

    // Expected beat k of a packet, straight from the packet format
    task automatic check_beat(input int k, input int n, input int tag, input logic [23:0] ty,
                              input logic [23:0] va, input logic [1:0] c, input logic [1:0] t,
                              input logic [31:0] d);
        logic [1:0]  ec, et;
        logic [31:0] ed;
        if (k == 0) begin
            ec = (n == 0) ? 2'b11 : 2'b01;
            et = 2'b01;
            ed = (32'(mgr_id) << 24) | (32'(n) << 16) | 32'(tag);
        end else begin
            ec = (k == n) ? 2'b10 : 2'b00;
            et = 2'b10;
            ed = (32'(ty[(k-1)*8 +: 8]) << 8) | 32'(va[(k-1)*8 +: 8]);
        end
        chk($sformatf("beat%0d_cntl", k), c, ec);
        chk($sformatf("beat%0d_type", k), t, et);
        chk($sformatf("beat%0d_data", k), d, ed);
    endtask

    task automatic run_packet(input logic [1:0] n, input logic [23:0] ty, input logic [23:0] va,
                              input bit rnd);
        int          et;
        logic [1:0]  c, t;
        logic [31:0] d;
        et = lowest_free();
        send_req(n, ty, va);
        chk("alloc_tag", bus.odc__wud__tag, et);
        chk("first_beat_latency", bus.mgr__std__oob_valid, 1);
        busy_m[et] = 1'b1;
        for (int k = 0; k <= int'(n); k++) begin
            take_beat(rnd, c, t, d);
            check_beat(k, n, et, ty, va, c, t, d);
        end
        bus.std__mgr__oob_ready = 1'b1;
    endtask

    initial begin
        logic [1:0]  c, t;
        logic [31:0] d;
        int          et;

        mgr_id                     = 8'h05;
        rel_tag                    = '0;
        bus.wud__odc__num_opts     = '0;
        bus.wud__odc__option_type  = '0;
        bus.wud__odc__option_value = '0;
        bus.std__mgr__oob_ready    = 1'b1;
        do_reset();

        // Reset state
        chk("rst_valid", bus.mgr__std__oob_valid, 0);
        chk("rst_cntl", bus.mgr__std__oob_cntl, 0);
        chk("rst_type", bus.mgr__std__oob_type, 0);
        chk("rst_data", bus.mgr__std__oob_data, 0);
        chk("rst_tag", bus.odc__wud__tag, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ready", bus.odc__wud__ready, 1);

        // Two-option packet
        run_packet(2'd2, 24'h00_22_11, 24'h00_B2_A1, 1'b0);
        chk("p1_idle_valid", bus.mgr__std__oob_valid, 0);
        chk("p1_outstanding", outstanding, 1);

        // Header-only packet
        run_packet(2'd0, 24'h0, 24'h0, 1'b0);
        chk("p2_idle_valid", bus.mgr__std__oob_valid, 0);
        chk("p2_idle_ready", bus.odc__wud__ready, 1);

        // Back-pressure during an option beat
        et = lowest_free();
        send_req(2'd2, 24'h00_66_55, 24'h00_C6_C5);
        chk("bp_tag", bus.odc__wud__tag, et);
        busy_m[et] = 1'b1;
        take_beat(1'b0, c, t, d);
        check_beat(0, 2, et, 24'h00_66_55, 24'h00_C6_C5, c, t, d);
        bus.std__mgr__oob_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {bus.mgr__std__oob_valid, bus.mgr__std__oob_cntl,
                            bus.mgr__std__oob_type, bus.mgr__std__oob_data},
                {1'b1, 2'b00, 2'b10, 32'h0000_55C5});
            step();
        end
        bus.std__mgr__oob_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            take_beat(1'b0, c, t, d);
            check_beat(k, 2, et, 24'h00_66_55, 24'h00_C6_C5, c, t, d);
        end
        chk("bp_outstanding", outstanding, busy_count());

        // Exhaust all eight tags
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_packet(2'($urandom_range(0, 3)), 24'($urandom), 24'($urandom), 1'b0);
            chk("fill_tag_order", bus.odc__wud__tag, i);
        end
        chk("full_stall", stall, 1);
        chk("full_ready", bus.odc__wud__ready, 0);
        chk("full_outstanding", outstanding, 8);
        release_tag(3'd3);
        busy_m[3] = 1'b0;
        chk("rel3_ready", bus.odc__wud__ready, 1);
        chk("rel3_stall", stall, 0);
        run_packet(2'd1, 24'h0000_77, 24'h0000_88, 1'b0);
        chk("rel3_realloc", bus.odc__wud__tag, 3);

        // Releasing a free tag
        release_tag(3'd5);
        busy_m[5] = 1'b0;
        chk("rel5_err_clean", tag_err, 0);
        chk("rel5_outstanding", outstanding, 7);
        release_tag(3'd5);
        chk("rel5_err_set", tag_err, 1);
        chk("rel5_bitmap_same", outstanding, 7);
        step();
        step();
        step();
        chk("rel5_err_sticky", tag_err, 1);

        // Release of tag 2 in the same cycle as an allocation
        et = lowest_free();
        bus.wud__odc__valid    = 1'b1;
        bus.wud__odc__num_opts = 2'd0;
        rel_valid              = 1'b1;
        rel_tag                = 3'd2;
        chk("coalloc_ready", bus.odc__wud__ready, 1);
        step();
        bus.wud__odc__valid = 1'b0;
        rel_valid           = 1'b0;
        busy_m[et]          = 1'b1;
        busy_m[2]           = 1'b0;
        chk("coalloc_tag", bus.odc__wud__tag, 5);
        chk("coalloc_outstanding", outstanding, 7);
        take_beat(1'b0, c, t, d);
        check_beat(0, 0, et, 24'h0, 24'h0, c, t, d);
        run_packet(2'd3, 24'hABCDEF, 24'h123456, 1'b0);
        chk("coalloc_next_tag", bus.odc__wud__tag, 2);

        // Reset during the header beat
        do_reset();
        bus.std__mgr__oob_ready = 1'b0;
        send_req(2'd1, 24'h0000_01, 24'h0000_02);
        chk("midrst_hdr_valid", bus.mgr__std__oob_valid, 1);
        reset_poweron = 1'b0;
        step();
        chk("midrst_valid", bus.mgr__std__oob_valid, 0);
        chk("midrst_outstanding", outstanding, 0);
        chk("midrst_idle", bus.odc__wud__ready, 1);
        reset_poweron           = 1'b1;
        bus.std__mgr__oob_ready = 1'b1;
        step();
        chk("midrst_after_valid", bus.mgr__std__oob_valid, 0);

        // Release of the very tag being allocated counts as a free-tag release
        bus.wud__odc__valid    = 1'b1;
        bus.wud__odc__num_opts = 2'd0;
        rel_valid              = 1'b1;
        rel_tag                = 3'd0;
        step();
        bus.wud__odc__valid = 1'b0;
        rel_valid           = 1'b0;
        chk("selfrel_tag", bus.odc__wud__tag, 0);
        chk("selfrel_err", tag_err, 1);
        chk("selfrel_outstanding", outstanding, 1);
        take_beat(1'b0, c, t, d);
        check_beat(0, 0, 0, 24'h0, 24'h0, c, t, d);

        // Randomized traffic against the model
        do_reset();
        mgr_id = 8'($urandom);
        for (int it = 0; it < 60; it++) begin
            if (busy_count() == 8 || $urandom_range(0, 3) == 0) begin
                logic [2:0] rt;
                rt = 3'($urandom_range(0, 7));
                if (busy_m[rt]) busy_m[rt] = 1'b0;
                else            err_m      = 1'b1;
                release_tag(rt);
            end else begin
                run_packet(2'($urandom_range(0, 3)), 24'($urandom), 24'($urandom), 1'b1);
            end
            chk("rnd_outstanding", outstanding, busy_count());
            chk("rnd_tag_err", tag_err, err_m);
            chk("rnd_stall", stall, busy_count() == 8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
